// File: rtl/counter_bank.sv
// counter_bank: NUM_CH independent up/down counters with a shared terminal
// value. Each channel supports clear, load (clamped to limit), increment and
// decrement. At the range ends a channel either wraps or saturates, and it
// raises a registered one-cycle terminal-count pulse.
module counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset_l,
    input  logic [WIDTH-1:0]        limit,
    input  logic [NUM_CH-1:0]       clear,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH-1:0]       inc,
    input  logic [NUM_CH-1:0]       dec,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       at_zero,
    output logic [NUM_CH-1:0]       at_limit,
    output logic [NUM_CH-1:0]       tc
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [NUM_CH*WIDTH-1:0] count_r;
    logic [NUM_CH*WIDTH-1:0] count_nxt_s;
    logic [NUM_CH-1:0]       tc_r;
    logic [NUM_CH-1:0]       tc_nxt_s;

    // Next state of a single channel, returned as {tc, count}.
    // Priority: clear > load > (inc xor dec) > hold. A count sitting above a
    // freshly lowered limit is left alone until an event touches it: inc
    // takes the terminal path, dec steps down, load clamps.
    function automatic logic [WIDTH:0] next_state(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] lim,
        input logic [WIDTH-1:0] lval,
        input logic             clr,
        input logic             ld,
        input logic             up,
        input logic             dn
    );
        logic [WIDTH-1:0] nxt;
        logic             term;
        nxt  = cur;
        term = 1'b0;
        if (clr) begin
            nxt = CNT_ZERO;
        end else if (ld) begin
            if (lval > lim) begin
                nxt = lim;
            end else begin
                nxt = lval;
            end
        end else if (up && !dn) begin
            if (cur < lim) begin
                nxt = cur + CNT_ONE;
            end else begin
                term = 1'b1;
                if (SATURATE) begin
                    nxt = lim;
                end else begin
                    nxt = CNT_ZERO;
                end
            end
        end else if (dn && !up) begin
            if (cur != CNT_ZERO) begin
                nxt = cur - CNT_ONE;
            end else begin
                term = 1'b1;
                if (SATURATE) begin
                    nxt = CNT_ZERO;
                end else begin
                    nxt = lim;
                end
            end
        end else begin
            // No request, or inc and dec together: hold.
            nxt = cur;
        end
        return {term, nxt};
    endfunction

    // Evaluate every channel's next count and terminal pulse.
    always_comb begin
        count_nxt_s = count_r;
        tc_nxt_s    = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            {tc_nxt_s[i], count_nxt_s[i*WIDTH +: WIDTH]} = next_state(
                count_r[i*WIDTH +: WIDTH], limit, load_val[i*WIDTH +: WIDTH],
                clear[i], load[i], inc[i], dec[i]);
        end
    end

    // Count and terminal-pulse registers; reset clears everything immediately.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            count_r <= {(NUM_CH*WIDTH){1'b0}};
            tc_r    <= {NUM_CH{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            tc_r    <= tc_nxt_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;

    // Status flags decode only the registered count and the live limit.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_status
        assign at_zero[g]  = (count_r[g*WIDTH +: WIDTH] == CNT_ZERO);
        assign at_limit[g] = (count_r[g*WIDTH +: WIDTH] >= limit);
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank. Two instances share all inputs: one in
// wrap mode and one in saturate mode; each scenario checks the relevant one.
module tb_counter_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;

    logic                    clock;
    logic                    reset_l;
    logic [WIDTH-1:0]        limit;
    logic [NUM_CH-1:0]       clear;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*WIDTH-1:0] load_val;
    logic [NUM_CH-1:0]       inc;
    logic [NUM_CH-1:0]       dec;

    logic [NUM_CH*WIDTH-1:0] count_w, count_s;
    logic [NUM_CH-1:0]       at_zero_w, at_zero_s;
    logic [NUM_CH-1:0]       at_limit_w, at_limit_s;
    logic [NUM_CH-1:0]       tc_w, tc_s;

    int n_checks;
    int n_fail;

    counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b0)) u_wrap (
        .clock(clock), .reset_l(reset_l), .limit(limit), .clear(clear),
        .load(load), .load_val(load_val), .inc(inc), .dec(dec),
        .count(count_w), .at_zero(at_zero_w), .at_limit(at_limit_w), .tc(tc_w)
    );

    counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b1)) u_sat (
        .clock(clock), .reset_l(reset_l), .limit(limit), .clear(clear),
        .load(load), .load_val(load_val), .inc(inc), .dec(dec),
        .count(count_s), .at_zero(at_zero_s), .at_limit(at_limit_s), .tc(tc_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] seq_cnt [7];
    logic       seq_tc  [7];
    logic [7:0] sat_cnt [5];
    logic       sat_tc  [5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_l  = 1'b0;
        limit    = 8'd5;
        clear    = 4'h0;
        load     = 4'h0;
        load_val = 32'h0;
        inc      = 4'h0;
        dec      = 4'h0;

        // Reset state
        #12;
        check_value("rst_count_w", count_w, 32'h0);
        check_value("rst_tc_w", {28'h0, tc_w}, 32'h0);
        check_value("rst_count_s", count_s, 32'h0);
        check_value("rst_at_zero", {28'h0, at_zero_w}, 32'hf);
        check_value("rst_at_limit", {28'h0, at_limit_w}, 32'h0);
        step();
        reset_l = 1'b1;

        // Wrap: seven incs on ch0 with limit 5
        seq_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
        seq_tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        inc = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            step();
            check_value($sformatf("wrap_inc_cnt%0d", i), {24'h0, count_w[7:0]}, {24'h0, seq_cnt[i]});
            check_value($sformatf("wrap_inc_tc%0d", i), {31'h0, tc_w[0]}, {31'h0, seq_tc[i]});
        end
        inc = 4'h0;
        check_value("wrap_others_zero", {8'h0, count_w[31:8]}, 32'h0);

        // Saturate: dec at 0 then five incs on ch1, limit 3
        clear = 4'hf;
        step();
        clear = 4'h0;
        limit = 8'd3;
        dec = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value($sformatf("sat_dec_cnt%0d", i), {24'h0, count_s[15:8]}, 32'h0);
            check_value($sformatf("sat_dec_tc%0d", i), {31'h0, tc_s[1]}, 32'h1);
        end
        dec = 4'h0;
        sat_cnt = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        sat_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        inc = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            check_value($sformatf("sat_inc_cnt%0d", i), {24'h0, count_s[15:8]}, {24'h0, sat_cnt[i]});
            check_value($sformatf("sat_inc_tc%0d", i), {31'h0, tc_s[1]}, {31'h0, sat_tc[i]});
        end
        inc = 4'h0;

        // Priority on ch2 (wrap instance), limit 10
        limit = 8'd10;
        load = 4'b0100;
        load_val = 32'h0004_0000;
        step();
        check_value("prio_setup", {24'h0, count_w[23:16]}, 32'd4);
        clear = 4'b0100;
        load_val = 32'h0002_0000;
        inc = 4'b0100;
        step();
        check_value("prio_clear", {24'h0, count_w[23:16]}, 32'd0);
        clear = 4'h0;
        step();
        check_value("prio_load", {24'h0, count_w[23:16]}, 32'd2);
        load = 4'h0;
        dec = 4'b0100;
        step();
        check_value("prio_incdec_cnt", {24'h0, count_w[23:16]}, 32'd2);
        check_value("prio_incdec_tc", {31'h0, tc_w[2]}, 32'h0);
        inc = 4'h0;
        dec = 4'h0;

        // Load clamp and limit change on ch3
        load = 4'b1000;
        load_val = 32'hC800_0000;
        step();
        check_value("clamp_load", {24'h0, count_w[31:24]}, 32'd10);
        load = 4'h0;
        limit = 8'd4;
        inc = 4'b1000;
        step();
        check_value("lower_inc_cnt", {24'h0, count_w[31:24]}, 32'd0);
        check_value("lower_inc_tc", {31'h0, tc_w[3]}, 32'h1);
        inc = 4'h0;
        limit = 8'd10;
        load = 4'b1000;
        load_val = 32'h0900_0000;
        step();
        load = 4'h0;
        limit = 8'd4;
        #1;
        check_value("above_limit_flag", {31'h0, at_limit_w[3]}, 32'h1);
        dec = 4'b1000;
        step();
        check_value("above_dec_cnt", {24'h0, count_w[31:24]}, 32'd8);
        check_value("above_dec_tc", {31'h0, tc_w[3]}, 32'h0);
        dec = 4'h0;

        // Wrap down on ch0, then limit 0
        clear = 4'b0001;
        step();
        clear = 4'h0;
        limit = 8'd7;
        dec = 4'b0001;
        step();
        check_value("wrapdn_cnt", {24'h0, count_w[7:0]}, 32'd7);
        check_value("wrapdn_tc", {31'h0, tc_w[0]}, 32'h1);
        dec = 4'h0;
        limit = 8'd0;
        inc = 4'b0001;
        step();
        check_value("lim0_cnt", {24'h0, count_w[7:0]}, 32'd0);
        check_value("lim0_tc", {31'h0, tc_w[0]}, 32'h1);
        check_value("lim0_at_zero", {31'h0, at_zero_w[0]}, 32'h1);
        check_value("lim0_at_limit", {31'h0, at_limit_w[0]}, 32'h1);
        inc = 4'h0;

        // Async reset mid-count
        limit = 8'd6;
        load = 4'hf;
        load_val = 32'h0601_0503;
        step();
        load = 4'h0;
        check_value("mid_loaded", count_w, 32'h0601_0503);
        inc = 4'hf;
        step();
        check_value("mid_inc_cnt", count_w, 32'h0002_0604);
        check_value("mid_inc_tc", {28'h0, tc_w}, 32'h8);
        #2;
        reset_l = 1'b0;
        #1;
        check_value("async_cnt", count_w, 32'h0);
        check_value("async_tc", {28'h0, tc_w}, 32'h0);
        check_value("async_at_zero", {28'h0, at_zero_w}, 32'hf);
        limit = 8'd0;
        #1;
        check_value("async_at_limit0", {28'h0, at_limit_w}, 32'hf);
        step();
        inc = 4'h0;
        reset_l = 1'b1;
        step();
        check_value("post_rst_cnt", count_w, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of NUM_CH independent up/down counters, WIDTH bits each, sharing one programmable terminal value. Each channel supports clear, load, increment and decrement, with wrap-around or saturation at the range ends and a registered terminal-count pulse. It replaces single-purpose up-counters in the timing, DMA-length and sprite/tile index logic, where several related counts advance against a common limit.

## Interface
- NUM_CH, 4, number of independent channels (>= 1)
- WIDTH, 8, bits per channel count (>= 2)
- SATURATE, 0, 0 = wrap mode, 1 = saturate mode (elaboration-time, applies to all channels)

- clock  input  1  system clock, all state on rising edge
- reset_l  input  1  asynchronous, active-low reset
- limit  input  WIDTH  shared terminal value; legal count range is 0..limit inclusive
- clear  input  NUM_CH  per-channel synchronous clear to 0
- load  input  NUM_CH  per-channel synchronous load
- load_val  input  NUM_CH*WIDTH  load values, channel i in bits [i*WIDTH +: WIDTH]
- inc  input  NUM_CH  per-channel increment request
- dec  input  NUM_CH  per-channel decrement request
- count  output  NUM_CH*WIDTH  registered counts, channel i in bits [i*WIDTH +: WIDTH]
- at_zero  output  NUM_CH  channel count == 0 (decoded from registered count)
- at_limit  output  NUM_CH  channel count >= limit (decoded from registered count and current limit)
- tc  output  NUM_CH  registered one-cycle terminal-count pulse

## Operation
- Channels are fully independent; the only shared input is limit.
- Per-channel priority, evaluated each cycle: clear > load > (inc xor dec) > hold.
- clear: count <= 0; tc <= 0.
- load: count <= min(load_val_i, limit); tc <= 0.
- inc only, count < limit: count <= count + 1; tc <= 0.
- inc only, count >= limit: wrap mode count <= 0; saturate mode count <= limit; tc <= 1 in both modes.
- dec only, count > 0: count <= count - 1; tc <= 0.
- dec only, count == 0: wrap mode count <= limit; saturate mode count <= 0; tc <= 1.
- inc and dec both asserted: treated as hold; count unchanged; tc <= 0.
- No request: count holds; tc <= 0.
- limit may change at any time. A count left above a newly lowered limit is not corrected until the next event: an inc takes the terminal path; a dec decrements normally; a load clamps.
- Arithmetic is WIDTH-bit unsigned. limit = 2^WIDTH-1 gives full-range behaviour. limit = 0 pins the count at 0, and every inc or dec produces tc.

## Timing
- Reset (reset_l low, asynchronous): every count = 0, every tc = 0. at_zero = all ones and at_limit follows limit (all ones when limit = 0).
- Release of reset is synchronous to clock. The first action takes effect on the first rising edge with reset_l high.
- Latency: a request sampled at edge N is visible on count and tc after edge N; tc is high for exactly that one cycle unless a terminal event repeats.
- Back-to-back incs at limit in wrap mode: count goes limit, 0, 1, ... with tc high only on the cycle count shows 0.
- Back-to-back incs at limit in saturate mode: tc is high every cycle the inc is held.
- at_zero and at_limit are combinational from registered state and the limit input. They have no added latency and no other combinational input paths.
- Reset mid-operation overrides all inputs immediately; no request is remembered.

## Test plan
- Reset/basic: NUM_CH=4, WIDTH=8, limit=5, wrap mode; pulse reset, then inc ch0 for 7 cycles -> count0 sequence 1,2,3,4,5,0,1; tc0 high only on the cycle count0 = 0; other channels stay 0.
- Saturate: SATURATE=1, limit=3, dec ch1 from 0 -> count1 stays 0 and tc1 high every cycle. Then 5 incs -> 1,2,3,3,3 with tc1 high on the 4th and 5th.
- Priority: same cycle assert clear, load (load_val=2) and inc on ch2 from count 4 -> count2 = 0. Load+inc -> 2. inc+dec -> hold at 2, tc2 = 0.
- Load clamp and limit change: limit=10, load 200 -> count = 10. Lower limit to 4, then inc -> wrap to 0 with tc. From count 9 with limit 4, dec -> 8.
- Wrap down: limit=7, dec from 0 -> count 7, tc high. limit=0, inc -> count 0, tc high, at_zero and at_limit both 1.
- Async reset mid-count: channels at 3,5,1,6 with incs pending; assert reset_l low between edges -> all counts 0 and tc 0 before the next edge.
